// File: rtl/fetch_pkg.sv
// fetch_pkg: FSM encoding and reset/interrupt PC defaults for the fetch stage.
// Also used by the control unit and the stack.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } fetch_state_e;

   localparam logic [15:0] NOP_INSTR       = 16'h0000;
   localparam logic [15:0] DEF_RESET_PC    = 16'd0;
   localparam logic [15:0] DEF_IRQ_VEC     = 16'd200;
   localparam int          DEF_TIMEOUT_CYC = 15;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter register.
// Load priority: reset > irq_load > branch > increment.
module fetch_pc_reg #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] IRQ_VEC  = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              irq_load,
   input  logic              br_load,
   input  logic              inc_load,
   input  logic [ADDR_W-1:0] br_addr,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (reset)
         pc <= RESET_PC;
      else if (irq_load)
         pc <= IRQ_VEC;
      else if (br_load)
         pc <= br_addr;
      else if (inc_load)
         pc <= pc + ADDR_W'(1);
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage, PC owner and program-memory read master.
// Build option FETCH_TIMEOUT_EN adds an ack timeout with a sticky fetch_err flag.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 16,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
   parameter logic [ADDR_W-1:0] IRQ_VEC     = ADDR_W'(DEF_IRQ_VEC),
   parameter int                TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs_fcu,
   input  logic              sel_fcu,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic              irq_load,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] pc,
   output logic              ready_fcu,
   output logic              fetch_err
);

   fetch_state_e      state;
   fetch_state_e      state_n;
   logic              start;
   logic              fetch_done;
   logic              sel_q;
   logic [ADDR_W-1:0] br_q;

`ifdef FETCH_TIMEOUT_EN
   logic [3:0] tmo_cnt;
   logic       tmo_hit;
   logic       err_q;
`endif

   always_comb begin
      state_n    = state;
      start      = 1'b0;
      fetch_done = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_hit    = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (cs_fcu == 1'b1) begin
               state_n = ST_REQ;
               start   = 1'b1;
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               state_n    = ST_DONE;
               fetch_done = 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (tmo_cnt == 4'(TIMEOUT_CYC - 1)) begin
               state_n = ST_ERR;
               tmo_hit = 1'b1;
            end
`endif
         end
`ifdef FETCH_TIMEOUT_EN
         ST_ERR:  state_n = ST_DONE;
`endif
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         instr    <= '0;
         sel_q    <= 1'b0;
         br_q     <= '0;
      end else begin
         state   <= state_n;
         mem_req <= (state_n == ST_REQ);
         if (start) begin
            mem_addr <= pc;
            sel_q    <= sel_fcu;
            br_q     <= br_addr;
         end
         if (fetch_done)
            instr <= mem_rdata;
`ifdef FETCH_TIMEOUT_EN
         else if (tmo_hit)
            instr <= DATA_W'(NOP_INSTR);
`endif
      end
   end

   assign ready_fcu = (state == ST_DONE);

`ifdef FETCH_TIMEOUT_EN
   // Counter idles at zero outside REQ, so it restarts on every REQ entry
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state != ST_REQ)
            tmo_cnt <= '0;
         else if (!mem_ack)
            tmo_cnt <= tmo_cnt + 4'd1;
         if (state == ST_ERR)
            err_q <= 1'b1;
      end
   end

   assign fetch_err = err_q;
`else
   assign fetch_err = 1'b0;
`endif

   fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC),
      .IRQ_VEC  (IRQ_VEC)
   ) u_pc (
      .clk      (clk),
      .reset    (reset),
      .irq_load (irq_load),
      .br_load  (fetch_done & ~sel_q),
      .inc_load (fetch_done & sel_q),
      .br_addr  (br_q),
      .pc       (pc)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// Expected fetches are queued by the stimulus and checked by a negedge monitor.
module tb_fetch_unit;

   localparam logic [15:0] IRQ_V = 16'd200;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs_fcu = 1'b0;
   logic        sel_fcu = 1'b0;
   logic [15:0] br_addr = '0;
   logic        irq_load = 1'b0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [15:0] instr;
   logic [15:0] pc;
   logic        ready_fcu;
   logic        fetch_err;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk       (clk),
      .reset     (reset),
      .cs_fcu    (cs_fcu),
      .sel_fcu   (sel_fcu),
      .br_addr   (br_addr),
      .irq_load  (irq_load),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .instr     (instr),
      .pc        (pc),
      .ready_fcu (ready_fcu),
      .fetch_err (fetch_err)
   );

   typedef struct {
      logic [15:0] addr;
      logic [15:0] ins;
      logic [15:0] npc;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] pc_m = '0;
   logic [15:0] seen_addr = '0;
   logic        prev_req = 1'b0;
   logic        prev_rdy = 1'b0;

   function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endfunction

   // Monitor: pops one expectation per ready_fcu pulse
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_req <= 1'b0;
         prev_rdy <= 1'b0;
      end else begin
         if (mem_req === 1'b1 && prev_req !== 1'b1)
            seen_addr <= mem_addr;
         if (mem_req === 1'b1 && prev_req === 1'b1)
            chk("addr_stable", mem_addr, seen_addr);
         if (ready_fcu === 1'b1) begin
            if (prev_rdy === 1'b1)
               chk("ready_width", 16'd2, 16'd1);
            if (q.size() == 0) begin
               chk("spurious_ready", 16'd1, 16'd0);
            end else begin
               e = q.pop_front();
               chk("instr", instr, e.ins);
               chk("pc", pc, e.npc);
               chk("mem_addr", seen_addr, e.addr);
            end
         end
         prev_req <= mem_req;
         prev_rdy <= ready_fcu;
      end
   end

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (mem_req === 1'b1)
            ok = 1'b1;
      end
      chk("req_wait", 16'(ok), 16'd1);
   endtask

   task automatic start(input logic s, input logic [15:0] b);
      @(posedge clk);
      #1;
      cs_fcu  = 1'b1;
      sel_fcu = s;
      br_addr = b;
   endtask

   task automatic serve(input logic s, input logic [15:0] b, input int dly,
                        input logic irq_ack, input logic hold,
                        input logic [15:0] d);
      exp_t e;
      bit   ok;
      wait_req(ok);
      if (!ok) begin
         cs_fcu = 1'b0;
         return;
      end
      if (!hold) begin
         cs_fcu  = 1'b0;
         sel_fcu = 1'($urandom);
         br_addr = 16'($urandom);
      end
      e.addr = pc_m;
      e.ins  = d;
      if (irq_ack)
         pc_m = IRQ_V;
      else if (s)
         pc_m = pc_m + 16'd1;
      else
         pc_m = b;
      e.npc = pc_m;
      q.push_back(e);
      repeat (dly - 1) @(posedge clk);
      if (dly > 1)
         #1;
      mem_ack   = 1'b1;
      mem_rdata = d;
      irq_load  = irq_ack;
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      irq_load  = 1'b0;
      mem_rdata = 16'($urandom);
      chk("ready_lat", 16'(ready_fcu), 16'd1);
      chk("req_drop", 16'(mem_req), 16'd0);
      @(negedge clk);
      #1;
      chk("drain", 16'(q.size()), 16'd0);
      q.delete();
   endtask

   task automatic fetch(input logic s, input logic [15:0] b, input int dly,
                        input logic irq_ack, input logic [15:0] d);
      start(s, b);
      serve(s, b, dly, irq_ack, 1'b0, d);
   endtask

   task automatic irq_idle();
      @(posedge clk);
      #1;
      irq_load = 1'b1;
      mem_ack  = 1'b1;
      @(posedge clk);
      #1;
      irq_load = 1'b0;
      mem_ack  = 1'b0;
      pc_m = IRQ_V;
      chk("irq_idle_pc", pc, pc_m);
      chk("irq_idle_req", 16'(mem_req), 16'd0);
   endtask

   initial begin
      bit          ok;
      logic        s;
      logic [15:0] b;
`ifdef FETCH_TIMEOUT_EN
      exp_t        e;
      int          cyc;
`endif
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_pc", pc, 16'd0);
      chk("rst_instr", instr, 16'd0);
      chk("rst_req", 16'(mem_req), 16'd0);
      chk("rst_addr", mem_addr, 16'd0);
      chk("rst_ready", 16'(ready_fcu), 16'd0);
      chk("rst_err", 16'(fetch_err), 16'd0);

      fetch(1'b1, 16'h0000, 2, 1'b0, 16'hA5A5);
      fetch(1'b0, 16'hFFFF, 1, 1'b0, 16'h1111);
      fetch(1'b1, 16'h1234, 3, 1'b0, 16'h2222);
      fetch(1'b0, 16'h0040, 2, 1'b0, 16'h3333);
      fetch(1'b1, 16'h0000, 1, 1'b0, 16'h4444);
      fetch(1'b0, 16'h0005, 1, 1'b0, 16'h5555);
      fetch(1'b1, 16'h0000, 2, 1'b1, 16'h6666);
      chk("irq_ack_pc", pc, IRQ_V);

      start(1'b1, 16'h0000);
      serve(1'b1, 16'h0000, 1, 1'b0, 1'b1, 16'h7777);
      serve(1'b1, 16'h0000, 2, 1'b0, 1'b0, 16'h8888);

      for (int i = 0; i < 30; i++) begin
         s = 1'($urandom);
         b = 16'($urandom);
         fetch(s, b, int'($urandom_range(1, 4)),
               ($urandom_range(0, 7) == 0), 16'($urandom));
         if ($urandom_range(0, 9) == 0)
            irq_idle();
      end
      fetch(1'b0, 16'h0009, 1, 1'b0, 16'h9999);
      irq_idle();

`ifdef FETCH_TIMEOUT_EN
      start(1'b1, 16'h0000);
      wait_req(ok);
      cs_fcu = 1'b0;
      e.addr = pc_m;
      e.ins  = 16'h0000;
      e.npc  = pc_m;
      q.push_back(e);
      cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (ready_fcu === 1'b1) begin
            cyc = i;
            break;
         end
      end
      chk("tmo_cycles", 16'(cyc), 16'd16);
      chk("tmo_err", 16'(fetch_err), 16'd1);
      @(negedge clk);
      #1;
      chk("tmo_drain", 16'(q.size()), 16'd0);
      q.delete();
`else
      chk("err_tied", 16'(fetch_err), 16'd0);
`endif

      start(1'b1, 16'h0000);
      wait_req(ok);
      cs_fcu = 1'b0;
      reset  = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      pc_m  = 16'd0;
      chk("rst_req_drop", 16'(mem_req), 16'd0);
      chk("rst_req_pc", pc, pc_m);
      chk("rst_req_ready", 16'(ready_fcu), 16'd0);
      chk("rst_req_err", 16'(fetch_err), 16'd0);
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      chk("late_ack_ready", 16'(ready_fcu), 16'd0);
      chk("late_ack_pc", pc, pc_m);
      chk("late_ack_instr", instr, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("late_ack_idle", 16'(mem_req), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
